reg_byte_unloader: RTL and testbench
====================================

REG_BYTE_UNLOADER -- requirements
Module: reg_byte_unloader

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 WordIn  input  16  register word to store to byte memory.
REQ-005 AddrIn  input  ADDR_W  byte address of first byte.
REQ-006 Mode  input  2  00 full word, 01 low byte only, 10 high byte only, 11 same as 00.
REQ-007 WordValid  input  1  word request offered.
REQ-008 WordReady  output  1  block can accept a word request.
REQ-009 ByteOut  output  8  byte to memory.
REQ-010 AddrOut  output  ADDR_W  memory address for ByteOut.
REQ-011 ByteValid  output  1  ByteOut/AddrOut valid.
REQ-012 ByteReady  input  1  memory accepts byte.
REQ-013 Busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, FIRST, SECOND; word accepted on WordValid&WordReady, byte transferred on ByteValid&ByteReady.
REQ-015 Acceptance SHALL capture WordIn, AddrIn, Mode into holding registers and enter FIRST next cycle (latency 1 cycle to first ByteValid).
REQ-016 ByteValid SHALL be high exactly in FIRST and SECOND; ByteOut/AddrOut SHALL stay stable while ByteValid&!ByteReady.
REQ-017 Mode 00/11: FIRST emits WordIn[7:0] at AddrIn, SECOND emits WordIn[15:8] at AddrIn+1.
REQ-018 Mode 01: FIRST emits WordIn[7:0] at AddrIn, then IDLE; Mode 10: FIRST emits WordIn[15:8] at AddrIn, then IDLE.
REQ-019 Address increment SHALL be modulo 2^ADDR_W (all-ones wraps to zero).
REQ-020 WordReady SHALL be high in IDLE, and in the final byte state when ByteReady is high (back-to-back acceptance, next word in FIRST the following cycle, no idle bubble).
REQ-021 Full-word throughput SHALL be 2 cycles/word with ByteReady held high; byte modes 1 cycle/word.
REQ-022 WordValid while not WordReady SHALL be ignored; request held by source until accepted.
REQ-023 ByteReady outside FIRST/SECOND SHALL have no effect.

Reset
REQ-024 Reset SHALL force IDLE; ByteValid=0, Busy=0, ByteOut=0x00, AddrOut=0, holding registers cleared.
REQ-025 Reset mid-transfer SHALL abandon pending bytes; WordReady=1 the cycle after Reset deasserts.
REQ-026 Reset SHALL dominate simultaneous WordValid/ByteReady.

Configuration
REQ-027 Macro REG_BYTE_UNLOADER_MSB_FIRST_EN defined: Mode 00/11 emits WordIn[15:8] at AddrIn then WordIn[7:0] at AddrIn+1.
REQ-028 Macro undefined: low byte first per REQ-017; byte modes unaffected either way.

Structure
REQ-029 Package reg_byte_unloader_pkg SHALL hold the state enum and Mode encodings (MODE_WORD, MODE_LO, MODE_HI).
REQ-030 One sub-module, byte_addr_counter: ADDR_W loadable counter with load/increment enables and wrap.

Verification
REQ-031 WordIn=0xABCD, AddrIn=0x0100, Mode=00, ByteReady=1 -> 0xCD@0x0100 then 0xAB@0x0101 on consecutive cycles, then Busy=0.
REQ-032 Same with REG_BYTE_UNLOADER_MSB_FIRST_EN -> 0xAB@0x0100 then 0xCD@0x0101.
REQ-033 Mode=10, WordIn=0x80FF, AddrIn=0xFFFF -> single byte 0x80@0xFFFF; Mode=00 same address -> second byte at 0x0000.
REQ-034 ByteReady low 3 cycles in FIRST -> ByteOut/AddrOut stable, WordReady=0; transfer completes on first ByteReady=1.
REQ-035 Two words 0x1234@0x10, 0x5678@0x20 WordValid held, ByteReady=1 -> bytes 34,12,78,56 at 0x10,0x11,0x20,0x21 in 4 consecutive cycles.
REQ-036 Reset asserted in SECOND -> next cycle ByteValid=0, AddrOut=0, state IDLE; pending byte never emitted.

Source files
------------

// File: rtl/reg_byte_unloader_pkg.sv
// Shared state and mode encodings for the register-to-byte unloader.
// Build option: REG_BYTE_UNLOADER_MSB_FIRST_EN (consumed by reg_byte_unloader).
package reg_byte_unloader_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FIRST  = 2'd1;
    localparam state_t ST_SECOND = 2'd2;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_WORD = 2'b00;
    localparam mode_t MODE_LO   = 2'b01;
    localparam mode_t MODE_HI   = 2'b10;

    // Encoding 2'b11 is an alias of MODE_WORD, so only LO/HI count as single-byte.
    function automatic logic is_byte_mode(input mode_t m);
        return (m == MODE_LO) || (m == MODE_HI);
    endfunction

endpackage

// File: rtl/byte_addr_counter.sv
// Loadable byte-address counter; increments wrap modulo 2^ADDR_W.
module byte_addr_counter #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Load,
    input  logic [ADDR_W-1:0] LoadValue,
    input  logic              Incr,
    output logic [ADDR_W-1:0] Count
);

    logic [ADDR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (Load) begin
            count_d = LoadValue;
        end else if (Incr) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/reg_byte_unloader.sv
// Splits a 16-bit register word into one or two byte writes with valid/ready handshakes.
// Define REG_BYTE_UNLOADER_MSB_FIRST_EN to emit the high byte first in full-word mode.
module reg_byte_unloader
    import reg_byte_unloader_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       WordIn,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic [1:0]        Mode,
    input  logic              WordValid,
    output logic              WordReady,
    output logic [7:0]        ByteOut,
    output logic [ADDR_W-1:0] AddrOut,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              Busy
);

    state_t      state_q, state_d;
    logic [15:0] word_q;
    mode_t       mode_q;

    logic        accept;
    logic        byte_xfer;
    logic        last_byte;
    logic        addr_incr;
    logic [7:0]  word_first;
    logic [7:0]  word_second;

`ifdef REG_BYTE_UNLOADER_MSB_FIRST_EN
    assign word_first  = word_q[15:8];
    assign word_second = word_q[7:0];
`else
    assign word_first  = word_q[7:0];
    assign word_second = word_q[15:8];
`endif

    assign ByteValid = (state_q == ST_FIRST) || (state_q == ST_SECOND);
    assign Busy      = (state_q != ST_IDLE);
    assign byte_xfer = ByteValid && ByteReady;
    assign last_byte = ((state_q == ST_FIRST) && is_byte_mode(mode_q)) ||
                       (state_q == ST_SECOND);
    // Accepting while the last byte drains lets the next word enter FIRST with no bubble.
    assign WordReady = (state_q == ST_IDLE) || (last_byte && ByteReady);
    assign accept    = WordValid && WordReady;
    assign addr_incr = (state_q == ST_FIRST) && byte_xfer && !is_byte_mode(mode_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (byte_xfer) begin
                    if (!is_byte_mode(mode_q)) begin
                        state_d = ST_SECOND;
                    end else begin
                        state_d = accept ? ST_FIRST : ST_IDLE;
                    end
                end
            end
            ST_SECOND: begin
                if (byte_xfer) begin
                    state_d = accept ? ST_FIRST : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ByteOut = 8'h00;
        case (state_q)
            ST_FIRST: begin
                if (mode_q == MODE_LO) begin
                    ByteOut = word_q[7:0];
                end else if (mode_q == MODE_HI) begin
                    ByteOut = word_q[15:8];
                end else begin
                    ByteOut = word_first;
                end
            end
            ST_SECOND: ByteOut = word_second;
            default:   ByteOut = 8'h00;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            mode_q  <= MODE_WORD;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= WordIn;
                mode_q <= Mode;
            end
        end
    end

    byte_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_addr_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (accept),
        .LoadValue(AddrIn),
        .Incr     (addr_incr),
        .Count    (AddrOut)
    );

endmodule

// File: tb/tb_reg_byte_unloader.sv
// Directed self-checking bench for reg_byte_unloader (ADDR_W = 16).
module tb_reg_byte_unloader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] WordIn;
    logic [15:0] AddrIn;
    logic [1:0]  Mode;
    logic        WordValid;
    logic        WordReady;
    logic [7:0]  ByteOut;
    logic [15:0] AddrOut;
    logic        ByteValid;
    logic        ByteReady;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REG_BYTE_UNLOADER_MSB_FIRST_EN
    localparam bit MsbFirst = 1'b1;
`else
    localparam bit MsbFirst = 1'b0;
`endif

    reg_byte_unloader #(
        .ADDR_W(16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WordIn   (WordIn),
        .AddrIn   (AddrIn),
        .Mode     (Mode),
        .WordValid(WordValid),
        .WordReady(WordReady),
        .ByteOut  (ByteOut),
        .AddrOut  (AddrOut),
        .ByteValid(ByteValid),
        .ByteReady(ByteReady),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] first_of(input logic [15:0] w);
        return MsbFirst ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_of(input logic [15:0] w);
        return MsbFirst ? w[7:0] : w[15:8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input logic [15:0] a);
        check({tag, ".valid"}, 32'(ByteValid), 32'd1);
        check({tag, ".byte"}, 32'(ByteOut), 32'(b));
        check({tag, ".addr"}, 32'(AddrOut), 32'(a));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(ByteValid), 32'd0);
        check({tag, ".busy"}, 32'(Busy), 32'd0);
        check({tag, ".ready"}, 32'(WordReady), 32'd1);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled on falling edges.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic sample();
        @(negedge Clock);
    endtask

    task automatic offer(input logic [15:0] w, input logic [15:0] a, input logic [1:0] m);
        WordIn    = w;
        AddrIn    = a;
        Mode      = m;
        WordValid = 1'b1;
    endtask

    initial begin
        // Reset dominates a simultaneous request and ByteReady
        Reset     = 1'b1;
        WordIn    = 16'h5A5A;
        AddrIn    = 16'h1234;
        Mode      = 2'b00;
        WordValid = 1'b1;
        ByteReady = 1'b1;
        step();
        step();
        sample();
        expect_idle("reset");
        check("reset.byte", 32'(ByteOut), 32'h00);
        check("reset.addr", 32'(AddrOut), 32'h0000);
        step();
        Reset     = 1'b0;
        WordValid = 1'b0;
        step();
        sample();
        expect_idle("post_reset");

        // Full word, ByteReady held high
        step();
        offer(16'hABCD, 16'h0100, 2'b00);
        sample();
        check("w0.ready_idle", 32'(WordReady), 32'd1);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("w0.first", first_of(16'hABCD), 16'h0100);
        check("w0.first.busy", 32'(Busy), 32'd1);
        check("w0.first.ready", 32'(WordReady), 32'd0);
        step();
        sample();
        expect_byte("w0.second", second_of(16'hABCD), 16'h0101);
        check("w0.second.ready", 32'(WordReady), 32'd1);
        step();
        sample();
        expect_idle("w0.done");

        // High byte only at the top address, then full word wrapping to zero
        offer(16'h80FF, 16'hFFFF, 2'b10);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("hi.first", 8'h80, 16'hFFFF);
        check("hi.first.ready", 32'(WordReady), 32'd1);
        step();
        sample();
        expect_idle("hi.done");
        offer(16'h80FF, 16'hFFFF, 2'b00);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("wrap.first", first_of(16'h80FF), 16'hFFFF);
        step();
        sample();
        expect_byte("wrap.second", second_of(16'h80FF), 16'h0000);
        step();
        sample();
        expect_idle("wrap.done");

        // Low byte only; mode 11 behaves as a full word
        offer(16'hBEEF, 16'h0050, 2'b01);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("lo.first", 8'hEF, 16'h0050);
        step();
        sample();
        expect_idle("lo.done");
        offer(16'h0102, 16'h0060, 2'b11);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("m3.first", first_of(16'h0102), 16'h0060);
        step();
        sample();
        expect_byte("m3.second", second_of(16'h0102), 16'h0061);
        step();
        sample();
        expect_idle("m3.done");

        // Backpressure in FIRST; a request offered meanwhile must be ignored
        ByteReady = 1'b0;
        offer(16'h1122, 16'h0300, 2'b00);
        step();
        offer(16'h9999, 16'h0777, 2'b01);
        for (int i = 0; i < 3; i++) begin
            sample();
            expect_byte("stall.first", first_of(16'h1122), 16'h0300);
            check("stall.ready", 32'(WordReady), 32'd0);
            step();
        end
        WordValid = 1'b0;
        ByteReady = 1'b1;
        sample();
        expect_byte("stall.release", first_of(16'h1122), 16'h0300);
        step();
        sample();
        expect_byte("stall.second", second_of(16'h1122), 16'h0301);
        step();
        sample();
        expect_idle("stall.done");

        // Two back-to-back words with no idle bubble
        offer(16'h1234, 16'h0010, 2'b00);
        step();
        offer(16'h5678, 16'h0020, 2'b00);
        sample();
        expect_byte("b2b.0", first_of(16'h1234), 16'h0010);
        check("b2b.0.ready", 32'(WordReady), 32'd0);
        step();
        sample();
        expect_byte("b2b.1", second_of(16'h1234), 16'h0011);
        check("b2b.1.ready", 32'(WordReady), 32'd1);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("b2b.2", first_of(16'h5678), 16'h0020);
        step();
        sample();
        expect_byte("b2b.3", second_of(16'h5678), 16'h0021);
        step();
        sample();
        expect_idle("b2b.done");

        // Reset while the second byte is pending
        offer(16'hCAFE, 16'h0400, 2'b00);
        step();
        WordValid = 1'b0;
        sample();
        expect_byte("rst.first", first_of(16'hCAFE), 16'h0400);
        step();
        sample();
        expect_byte("rst.second", second_of(16'hCAFE), 16'h0401);
        Reset = 1'b1;
        sample();
        check("rst.valid", 32'(ByteValid), 32'd0);
        check("rst.addr", 32'(AddrOut), 32'h0000);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.byte", 32'(ByteOut), 32'h00);
        step();
        Reset = 1'b0;
        sample();
        expect_idle("rst.after1");
        step();
        sample();
        expect_idle("rst.after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
